// File: rtl/tvp_sync_conditioner.sv
// Per-channel conditioning of the raw TVP sync inputs: synchronize, polarity-correct,
// glitch-filter, edge strobes, high-pulse width measurement and activity/loss detection.
module tvp_sync_conditioner #(
    parameter int unsigned               NUM_CH      = 3,
    parameter int unsigned               SYNC_STAGES = 2,
    parameter int unsigned               FILT_W      = 4,
    parameter int unsigned               WIDTH_W     = 8,
    parameter int unsigned               TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0]      TIMEOUT     = 20'd270000
) (
    input  logic                         TVP_PCLK_i,
    input  logic                         po_reset_n,
    input  logic [NUM_CH-1:0]            sync_i,
    input  logic [NUM_CH-1:0]            invert_i,
    input  logic [FILT_W-1:0]            filt_len_i,
    output logic [NUM_CH-1:0]            sync_o,
    output logic [NUM_CH-1:0]            rise_o,
    output logic [NUM_CH-1:0]            fall_o,
    output logic [NUM_CH*WIDTH_W-1:0]    width_o,
    output logic [NUM_CH-1:0]            width_valid_o,
    output logic [NUM_CH-1:0]            active_o,
    output logic [NUM_CH-1:0]            lost_o
);

    localparam int unsigned SYNC_MSB = SYNC_STAGES - 1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FILT_W-1:0]      fcnt_q;
        logic                   filt_q;
        logic                   rise_q;
        logic                   fall_q;
        logic [WIDTH_W-1:0]     wcnt_q;
        logic [WIDTH_W-1:0]     width_q;
        logic                   wvalid_q;
        logic [TIMEOUT_W-1:0]   tcnt_q;
        logic                   active_q;
        logic                   lost_q;
        logic                   s_c;
        logic                   mismatch_c;
        logic                   commit_c;

        // Metastability chain on the raw pin; stage 0 is the capture flop.
        always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
            if (!po_reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sync_i[k]};
            end
        end

        // Polarity is applied after synchronization, so a toggle of invert_i is filtered like a pin edge.
        assign s_c        = sync_q[SYNC_MSB] ^ invert_i[k];
        assign mismatch_c = (s_c != filt_q);
        assign commit_c   = mismatch_c && (fcnt_q >= filt_len_i);

        // Glitch filter: new level must persist filt_len_i+1 cycles before it is committed.
        always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
            if (!po_reset_n) begin
                filt_q <= 1'b0;
                fcnt_q <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= commit_c &  s_c;
                fall_q <= commit_c & ~s_c;
                if (!mismatch_c) begin
                    fcnt_q <= '0;
                end else if (commit_c) begin
                    filt_q <= s_c;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + FILT_W'(1);
                end
            end
        end

        // High-pulse width: count cycles with filtered sync high, publish on the fall.
        always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
            if (!po_reset_n) begin
                wcnt_q   <= '0;
                width_q  <= '0;
                wvalid_q <= 1'b0;
            end else begin
                wvalid_q <= 1'b0;
                if (commit_c && s_c) begin
                    wcnt_q <= WIDTH_W'(1);
                end else if (commit_c && !s_c) begin
                    width_q  <= wcnt_q;
                    wvalid_q <= 1'b1;
                end else if (filt_q && (wcnt_q != '1)) begin
                    wcnt_q <= wcnt_q + WIDTH_W'(1);
                end
            end
        end

        // Activity watchdog; an edge coinciding with the timeout keeps the channel active.
        always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
            if (!po_reset_n) begin
                tcnt_q   <= TIMEOUT;
                active_q <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                lost_q <= 1'b0;
                if (commit_c) begin
                    tcnt_q   <= '0;
                    active_q <= 1'b1;
                end else begin
                    if (tcnt_q != TIMEOUT) begin
                        tcnt_q <= tcnt_q + TIMEOUT_W'(1);
                    end
                    if ((tcnt_q == TIMEOUT) && active_q) begin
                        active_q <= 1'b0;
                        lost_q   <= 1'b1;
                    end
                end
            end
        end

        assign sync_o[k]                      = filt_q;
        assign rise_o[k]                      = rise_q;
        assign fall_o[k]                      = fall_q;
        assign width_o[k*WIDTH_W +: WIDTH_W]  = width_q;
        assign width_valid_o[k]               = wvalid_q;
        assign active_o[k]                    = active_q;
        assign lost_o[k]                      = lost_q;
    end

endmodule

// File: tb/tb_tvp_sync_conditioner.sv
// Directed bench for tvp_sync_conditioner: filter, width, polarity, activity, race and reset.
module tb_tvp_sync_conditioner;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned WIDTH_W = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_CH-1:0]         sync_i;
    logic [NUM_CH-1:0]         invert_i;
    logic [3:0]                filt_len;
    logic [NUM_CH-1:0]         sync_o;
    logic [NUM_CH-1:0]         rise_o;
    logic [NUM_CH-1:0]         fall_o;
    logic [NUM_CH*WIDTH_W-1:0] width_o;
    logic [NUM_CH-1:0]         width_valid_o;
    logic [NUM_CH-1:0]         active_o;
    logic [NUM_CH-1:0]         lost_o;

    int checks   = 0;
    int failures = 0;

    tvp_sync_conditioner #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(2),
        .FILT_W     (4),
        .WIDTH_W    (WIDTH_W),
        .TIMEOUT_W  (20),
        .TIMEOUT    (20'd100)
    ) dut (
        .TVP_PCLK_i   (clk),
        .po_reset_n   (rst_n),
        .sync_i       (sync_i),
        .invert_i     (invert_i),
        .filt_len_i   (filt_len),
        .sync_o       (sync_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .width_o      (width_o),
        .width_valid_o(width_valid_o),
        .active_o     (active_o),
        .lost_o       (lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sync_o, rise_o, fall_o, width_valid_o, active_o, lost_o} !== 18'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0", {sync_o, rise_o, fall_o, width_valid_o, active_o, lost_o});
        end
        checks++;
        if (width_o !== 24'd0) begin
            failures++;
            $display("FAIL reset_width: got %h expected 0", width_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_filter();
        logic seen;
        int hi, nrise, nfall, nvalid, both;
        logic [7:0] w;
        filt_len = 4'd3;
        step(2);
        // 3-cycle glitch must vanish
        sync_i[0] = 1'b1;
        step(3);
        sync_i[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen |= sync_o[0] | rise_o[0] | fall_o[0];
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL filter_glitch: got activity 1 expected 0");
        end
        checks++;
        if (active_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL filter_glitch_active: got %b expected 0", active_o[0]);
        end
        // 4-cycle pulse passes with 6-cycle latency
        sync_i[0] = 1'b1;
        step(4);
        sync_i[0] = 1'b0;
        step(1);
        checks++;
        if (sync_o[0] !== 1'b0 || rise_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL filter_early: got sync=%b rise=%b expected 0 0", sync_o[0], rise_o[0]);
        end
        step(1);
        checks++;
        if (sync_o[0] !== 1'b1 || rise_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL filter_rise_latency: got sync=%b rise=%b expected 1 1", sync_o[0], rise_o[0]);
        end
        hi = 1; nrise = 0; nfall = 0; nvalid = 0; both = 0; w = 8'hxx;
        for (int i = 0; i < 10; i++) begin
            step(1);
            hi     += int'(sync_o[0]);
            nrise  += int'(rise_o[0]);
            nfall  += int'(fall_o[0]);
            both   += int'(rise_o[0] & fall_o[0]);
            if (width_valid_o[0]) begin
                nvalid++;
                w = width_o[7:0];
            end
        end
        checks++;
        if (hi != 4) begin
            failures++;
            $display("FAIL filter_high_cycles: got %0d expected 4", hi);
        end
        checks++;
        if (nrise != 0 || nfall != 1 || both != 0) begin
            failures++;
            $display("FAIL filter_strobes: got rise=%0d fall=%0d both=%0d expected 0 1 0", nrise, nfall, both);
        end
        checks++;
        if (nvalid != 1 || w !== 8'd4) begin
            failures++;
            $display("FAIL filter_width: got valid=%0d width=%0d expected 1 4", nvalid, w);
        end
    endtask

    task automatic test_width();
        int nvalid;
        logic [7:0] w;
        filt_len = 4'd0;
        step(5);
        sync_i[1] = 1'b1;
        step(44);
        sync_i[1] = 1'b0;
        nvalid = 0; w = 8'hxx;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (width_valid_o[1]) begin
                nvalid++;
                w = width_o[15:8];
            end
        end
        checks++;
        if (nvalid != 1 || w !== 8'd44) begin
            failures++;
            $display("FAIL width_44: got valid=%0d width=%0d expected 1 44", nvalid, w);
        end
        sync_i[1] = 1'b1;
        step(150);
        checks++;
        if (width_o[15:8] !== 8'd44) begin
            failures++;
            $display("FAIL width_hold: got %0d expected 44", width_o[15:8]);
        end
        step(150);
        sync_i[1] = 1'b0;
        nvalid = 0; w = 8'hxx;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (width_valid_o[1]) begin
                nvalid++;
                w = width_o[15:8];
            end
        end
        checks++;
        if (nvalid != 1 || w !== 8'd255) begin
            failures++;
            $display("FAIL width_saturate: got valid=%0d width=%0d expected 1 255", nvalid, w);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        logic [7:0] w;
        sync_i[1] = 1'b1;
        step(3);
        checks++;
        if (rise_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre_rise: got %b expected 1", rise_o[1]);
        end
        step(19);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sync_o, rise_o, fall_o, width_valid_o, active_o, lost_o} !== 18'd0 || width_o !== 24'd0) begin
            failures++;
            $display("FAIL rstmid_async_clear: got flags=%b width=%h expected 0 0",
                     {sync_o, rise_o, fall_o, width_valid_o, active_o, lost_o}, width_o);
        end
        step(2);
        rst_n = 1'b1;
        step(2);
        checks++;
        if (sync_o[1] !== 1'b0 || rise_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_early: got sync=%b rise=%b expected 0 0", sync_o[1], rise_o[1]);
        end
        step(1);
        checks++;
        if (rise_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_rise: got %b expected 1", rise_o[1]);
        end
        step(12);
        sync_i[1] = 1'b0;
        nvalid = 0; w = 8'hxx;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (width_valid_o[1]) begin
                nvalid++;
                w = width_o[15:8];
            end
        end
        checks++;
        if (nvalid != 1 || w !== 8'd15) begin
            failures++;
            $display("FAIL rstmid_width: got valid=%0d width=%0d expected 1 15", nvalid, w);
        end
    endtask

    task automatic test_polarity();
        int nrise, nother, nvalid;
        logic [7:0] w;
        sync_i   = '0;
        invert_i = 3'b100;
        filt_len = 4'd0;
        test_reset();
        nrise = 0; nother = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            nrise  += int'(rise_o[2]);
            nother += int'(rise_o[1]) + int'(rise_o[0]) + int'(fall_o[2]);
        end
        checks++;
        if (nrise != 1 || nother != 0 || sync_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL polarity_rise: got rise=%0d other=%0d sync=%b expected 1 0 1", nrise, nother, sync_o[2]);
        end
        sync_i[2] = 1'b1;
        step(8);
        for (int p = 0; p < 2; p++) begin
            sync_i[2] = 1'b0;
            step(10);
            sync_i[2] = 1'b1;
            nvalid = 0; w = 8'hxx;
            for (int i = 0; i < 8; i++) begin
                step(1);
                if (width_valid_o[2]) begin
                    nvalid++;
                    w = width_o[23:16];
                end
            end
            checks++;
            if (nvalid != 1 || w !== 8'd10) begin
                failures++;
                $display("FAIL polarity_width_%0d: got valid=%0d width=%0d expected 1 10", p, nvalid, w);
            end
        end
    endtask

    task automatic test_activity();
        int drops, losts;
        sync_i[0] = 1'b1;
        step(3);
        checks++;
        if (rise_o[0] !== 1'b1 || active_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL act_start: got rise=%b active=%b expected 1 1", rise_o[0], active_o[0]);
        end
        step(100);
        checks++;
        if (active_o[0] !== 1'b1 || lost_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL act_hold_100: got active=%b lost=%b expected 1 0", active_o[0], lost_o[0]);
        end
        step(1);
        checks++;
        if (active_o[0] !== 1'b0 || lost_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL act_drop_101: got active=%b lost=%b expected 0 1", active_o[0], lost_o[0]);
        end
        step(1);
        checks++;
        if (lost_o[0] !== 1'b0 || active_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL act_lost_single: got lost=%b active=%b expected 0 0", lost_o[0], active_o[0]);
        end
        drops = 0; losts = 0;
        for (int n = 0; n < 5; n++) begin
            sync_i[0] = ~sync_i[0];
            for (int j = 0; j < 100; j++) begin
                step(1);
                if ((n > 0 || j >= 2) && active_o[0] !== 1'b1) drops++;
                losts += int'(lost_o[0]);
            end
        end
        checks++;
        if (drops != 0 || losts != 0) begin
            failures++;
            $display("FAIL act_periodic: got drops=%0d lost=%0d expected 0 0", drops, losts);
        end
    endtask

    task automatic test_race();
        int bad;
        step(150);
        checks++;
        if (active_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL race_idle: got active=%b expected 0", active_o[0]);
        end
        sync_i[0] = ~sync_i[0];
        step(3);
        checks++;
        if (active_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL race_first_edge: got active=%b expected 1", active_o[0]);
        end
        step(98);
        sync_i[0] = ~sync_i[0];
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            step(1);
            if (active_o[0] !== 1'b1 || lost_o[0] !== 1'b0) bad++;
            if (j == 2 && (rise_o[0] | fall_o[0]) !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL race_edge_wins: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        sync_i   = '0;
        invert_i = '0;
        filt_len = 4'd0;
        test_reset();
        test_filter();
        test_width();
        test_reset_mid();
        test_polarity();
        test_activity();
        test_race();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
